// File: rtl/dac_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_rd_pkg
// Brief    : Shared types and constants for the DAC playback read scheduler:
//            FSM states, DataMover MM2S command/status layout, status check.
// Revision : 1.0 - initial release
// ============================================================================
package dac_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Command word: low 32 bits are fixed format, then SADDR, TAG, reserved.
    localparam int c_CMD_BTT_LSB   = 0;
    localparam int c_CMD_BTT_MAX_W = 23;
    localparam int c_CMD_TYPE_BIT  = 23;
    localparam int c_CMD_DSA_LSB   = 24;
    localparam int c_CMD_EOF_BIT   = 30;
    localparam int c_CMD_DRR_BIT   = 31;
    localparam int c_CMD_SADDR_LSB = 32;
    localparam int c_CMD_TAG_W     = 4;
    localparam int c_CMD_RSVD_W    = 4;

    typedef struct packed {
        logic        drr;
        logic        eof;
        logic [5:0]  dsa;
        logic        incr;
        logic [22:0] btt;
    } dm_cmd_lo_t;

    localparam int c_STS_TAG_LSB = 0;
    localparam int c_STS_INTERR  = 4;
    localparam int c_STS_DECERR  = 5;
    localparam int c_STS_SLVERR  = 6;
    localparam int c_STS_OKAY    = 7;

    function automatic logic is_sts_err(input logic [7:0] sts);
        return sts[c_STS_INTERR] | sts[c_STS_DECERR] | sts[c_STS_SLVERR] | ~sts[c_STS_OKAY];
    endfunction

endpackage : dac_rd_pkg
`default_nettype wire

// File: rtl/dac_rd_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : dac_rd_cmd_sched
// Brief    : Splits a DAC playback capture into DataMover MM2S commands,
//            bounds outstanding commands and tracks status/progress.
//            Optional DAC_RD_LOOP_EN adds loop_en for repeated passes.
// Revision : 1.0 - initial release
// ============================================================================
module dac_rd_cmd_sched
    import dac_rd_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int BTT_W           = 23,
    parameter int CHUNK_BYTES     = 65536,
    parameter int MAX_OUTSTANDING = 4,
    parameter int BEAT_BYTES      = 32
) (
`ifdef DAC_RD_LOOP_EN
    input  logic                 loop_en,
`endif
    input  logic                 pl_clk,
    input  logic                 pl_rstb,
    input  logic                 read_start,
    input  logic                 read_reset,
    input  logic [ADDR_W-1:0]    start_address,
    input  logic [31:0]          cap_size,
    output logic [39+ADDR_W:0]   cmd_tdata,
    output logic                 cmd_tvalid,
    input  logic                 cmd_tready,
    input  logic [7:0]           sts_tdata,
    input  logic                 sts_tvalid,
    output logic                 sts_tready,
    output logic [ADDR_W-1:0]    current_addr,
    output logic [31:0]          run_cycles,
    output logic                 read_mm2s_err,
    output logic                 busy,
    output logic                 done
);

    localparam int                  c_OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_OUT_W-1:0]  c_MAX_OUT    = c_OUT_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0]   c_ADDR_MASK  = ADDR_W'(BEAT_BYTES - 1);
    localparam logic [31:0]         c_SIZE_MASK  = 32'(BEAT_BYTES - 1);
    localparam logic [31:0]         c_CHUNK      = 32'(CHUNK_BYTES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_start_d;
    logic [ADDR_W-1:0]    r_addr;
    logic [31:0]          r_remaining;
    logic [BTT_W-1:0]     r_btt;
    logic [3:0]           r_tag;
    logic [c_OUT_W-1:0]   r_outstanding;
    logic                 r_cmd_valid;
    logic [39+ADDR_W:0]   r_cmd_data;
    logic                 r_stop;
    logic                 r_abort;
    logic                 r_done;
    logic                 r_err;
    logic [ADDR_W-1:0]    r_current_addr;
    logic [31:0]          r_run_cycles;
`ifdef DAC_RD_LOOP_EN
    logic [ADDR_W-1:0]    r_loop_addr;
    logic [31:0]          r_loop_size;
`endif

    logic                 w_start_edge;
    logic                 w_misaligned;
    logic                 w_hs;
    logic                 w_sts_dec;
    logic                 w_sts_bad;
    logic                 w_stop;
    logic                 w_loop;
    logic [31:0]          w_btt_32;
    logic [31:0]          w_rem_after;
    logic                 w_issue;
    logic                 w_reload;
    logic                 w_enter_idle;
    logic [39+ADDR_W:0]   w_cmd;
    dm_cmd_lo_t           w_cmd_lo;
    logic                 w_unused_sts_tag;

    assign w_start_edge = read_start & ~r_start_d & ~read_reset & (r_state == IDLE);
    assign w_misaligned = ((start_address & c_ADDR_MASK) != '0) || ((cap_size & c_SIZE_MASK) != '0);
    assign w_hs         = r_cmd_valid & cmd_tready;
    assign w_sts_dec    = sts_tvalid & (r_outstanding != '0);
    assign w_sts_bad    = sts_tvalid & (is_sts_err(sts_tdata) | (r_outstanding == '0));
    assign w_stop       = r_stop | read_reset | w_sts_bad;
    assign w_btt_32     = (r_remaining < c_CHUNK) ? r_remaining : c_CHUNK;
    assign w_rem_after  = r_remaining - 32'(r_btt);
    assign w_unused_sts_tag = ^sts_tdata[3:0];

`ifdef DAC_RD_LOOP_EN
    assign w_loop = loop_en & read_start & ~w_stop;
`else
    assign w_loop = 1'b0;
`endif

    always_comb begin
        w_cmd_lo      = '0;
        w_cmd_lo.btt  = 23'(w_btt_32);
        w_cmd_lo.incr = 1'b1;
        w_cmd_lo.eof  = (w_btt_32 == r_remaining);
        w_cmd         = {4'h0, r_tag, r_addr, w_cmd_lo};
    end

    always_ff @(posedge pl_clk or negedge pl_rstb) begin
        if (!pl_rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_reload     = 1'b0;
        w_enter_idle = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_edge && (cap_size != '0) && !w_misaligned) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_hs && (w_rem_after == '0)) begin
                    if (w_loop) begin
                        w_reload = 1'b1;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end else if (!r_cmd_valid || w_hs) begin
                    // A pending command always completes before stopping.
                    if (w_stop) begin
                        w_state_nxt = DRAIN;
                    end else if (!r_cmd_valid && (r_outstanding < c_MAX_OUT)) begin
                        w_issue = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (r_outstanding == '0) begin
                    w_state_nxt  = IDLE;
                    w_enter_idle = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pl_clk or negedge pl_rstb) begin
        if (!pl_rstb) begin
            r_start_d      <= 1'b0;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_btt          <= '0;
            r_tag          <= '0;
            r_outstanding  <= '0;
            r_cmd_valid    <= 1'b0;
            r_cmd_data     <= '0;
            r_stop         <= 1'b0;
            r_abort        <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_current_addr <= '0;
            r_run_cycles   <= '0;
`ifdef DAC_RD_LOOP_EN
            r_loop_addr    <= '0;
            r_loop_size    <= '0;
`endif
        end else begin
            r_start_d <= read_start;

            if (w_start_edge) begin
                r_addr       <= start_address;
                r_remaining  <= cap_size;
                r_done       <= (cap_size == '0) || w_misaligned;
                r_err        <= (cap_size != '0) && w_misaligned;
                r_run_cycles <= '0;
                r_stop       <= 1'b0;
                r_abort      <= 1'b0;
`ifdef DAC_RD_LOOP_EN
                r_loop_addr  <= start_address;
                r_loop_size  <= cap_size;
`endif
            end else if ((r_state == IDLE) && read_reset) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end

            if (w_sts_bad) begin
                r_err <= 1'b1;
            end

            if (r_state != IDLE) begin
                if (read_reset) begin
                    r_abort <= 1'b1;
                end
                if (read_reset || w_sts_bad) begin
                    r_stop <= 1'b1;
                end
                if (r_run_cycles != 32'hFFFF_FFFF) begin
                    r_run_cycles <= r_run_cycles + 32'd1;
                end
            end

            if (w_issue) begin
                r_cmd_valid <= 1'b1;
                r_btt       <= BTT_W'(w_btt_32);
                r_cmd_data  <= w_cmd;
            end

            if (w_hs) begin
                r_cmd_valid    <= 1'b0;
                r_current_addr <= r_addr;
                r_addr         <= r_addr + ADDR_W'(r_btt);
                r_remaining    <= w_rem_after;
                r_tag          <= r_tag + 4'd1;
            end

            if (w_reload) begin
`ifdef DAC_RD_LOOP_EN
                r_addr      <= r_loop_addr;
                r_remaining <= r_loop_size;
`endif
            end

            if (w_hs && !w_sts_dec) begin
                r_outstanding <= r_outstanding + c_OUT_W'(1);
            end else if (!w_hs && w_sts_dec) begin
                r_outstanding <= r_outstanding - c_OUT_W'(1);
            end

            // An aborted run returns to IDLE without signalling completion.
            if (w_enter_idle) begin
                r_done <= ~r_abort & ~read_reset;
            end
        end
    end

    assign cmd_tdata     = r_cmd_data;
    assign cmd_tvalid    = r_cmd_valid;
    assign sts_tready    = 1'b1;
    assign current_addr  = r_current_addr;
    assign run_cycles    = r_run_cycles;
    assign read_mm2s_err = r_err;
    assign busy          = (r_state != IDLE);
    assign done          = r_done;

endmodule : dac_rd_cmd_sched
`default_nettype wire

// File: tb/tb_dac_rd_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_rd_cmd_sched
// Brief    : Directed self-checking bench for dac_rd_cmd_sched with a command
//            scoreboard and an optional auto-status responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_rd_cmd_sched;

    logic        pl_clk = 1'b0;
    logic        pl_rstb;
    logic        read_start;
    logic        read_reset;
    logic [31:0] start_address;
    logic [31:0] cap_size;
    logic [71:0] cmd_tdata;
    logic        cmd_tvalid;
    logic        cmd_tready;
    logic [7:0]  sts_tdata;
    logic        sts_tvalid;
    logic        sts_tready;
    logic [31:0] current_addr;
    logic [31:0] run_cycles;
    logic        read_mm2s_err;
    logic        busy;
    logic        done;
`ifdef DAC_RD_LOOP_EN
    logic        loop_en;
`endif

    dac_rd_cmd_sched #(
        .ADDR_W          (32),
        .BTT_W           (23),
        .CHUNK_BYTES     (65536),
        .MAX_OUTSTANDING (4),
        .BEAT_BYTES      (32)
    ) u_dut (
`ifdef DAC_RD_LOOP_EN
        .loop_en       (loop_en),
`endif
        .pl_clk        (pl_clk),
        .pl_rstb       (pl_rstb),
        .read_start    (read_start),
        .read_reset    (read_reset),
        .start_address (start_address),
        .cap_size      (cap_size),
        .cmd_tdata     (cmd_tdata),
        .cmd_tvalid    (cmd_tvalid),
        .cmd_tready    (cmd_tready),
        .sts_tdata     (sts_tdata),
        .sts_tvalid    (sts_tvalid),
        .sts_tready    (sts_tready),
        .current_addr  (current_addr),
        .run_cycles    (run_cycles),
        .read_mm2s_err (read_mm2s_err),
        .busy          (busy),
        .done          (done)
    );

    always #5 pl_clk = ~pl_clk;

    typedef struct {
        int         due;
        logic [3:0] tag;
    } sts_pend_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          n_cmds = 0;
    int          busy_cnt = 0;
    int          n0;
    logic        auto_sts = 1'b0;
    logic        prev_pend = 1'b0;
    logic [71:0] prev_data = '0;
    logic [3:0]  exp_tag = '0;
    logic [71:0] exp_q[$];
    sts_pend_t   sts_q[$];

    function automatic logic [71:0] mk_cmd(input logic [31:0] a, input logic [22:0] btt,
                                           input logic eof, input logic [3:0] tag);
        return {4'h0, tag, a, 1'b0, eof, 6'h00, 1'b1, btt};
    endfunction

    task automatic chk(input string name, input logic [79:0] obs, input logic [79:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [22:0] btt, input logic eof);
        exp_q.push_back(mk_cmd(a, btt, eof, exp_tag));
        exp_tag = exp_tag + 4'd1;
    endtask

    task automatic step();
        logic [71:0] e;
        sts_pend_t   p;
        @(negedge pl_clk);
        if (prev_pend) chk("cmd_hold", {7'd0, cmd_tvalid, cmd_tdata}, {7'd0, 1'b1, prev_data});
        if (busy) busy_cnt++;
        if (cmd_tvalid && cmd_tready) begin
            n_cmds++;
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL cmd_unexpected: observed %0h expected none", cmd_tdata);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("cmd", 80'(cmd_tdata), 80'(e));
            end
            if (auto_sts) begin
                p.due = cyc + 20;
                p.tag = cmd_tdata[67:64];
                sts_q.push_back(p);
            end
        end
        prev_pend = cmd_tvalid && !cmd_tready;
        prev_data = cmd_tdata;
        @(posedge pl_clk);
        #1;
        cyc++;
        if (auto_sts) begin
            sts_tvalid = 1'b0;
            if (sts_q.size() != 0 && sts_q[0].due <= cyc) begin
                p = sts_q.pop_front();
                sts_tvalid = 1'b1;
                sts_tdata  = {4'h8, p.tag};
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_sts(input logic [7:0] s);
        sts_tdata  = s;
        sts_tvalid = 1'b1;
        step();
        sts_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            step();
            k++;
        end
        chk({name, "_timeout"}, 80'(busy), 80'(0));
    endtask

    task automatic wait_cmds(input string name, input int n, input int bound);
        int k;
        k = 0;
        while (n_cmds < n && k < bound) begin
            step();
            k++;
        end
        chk({name, "_timeout"}, 80'(n_cmds >= n), 80'(1));
    endtask

    task automatic do_reset();
        pl_rstb       = 1'b0;
        read_start    = 1'b0;
        read_reset    = 1'b0;
        start_address = '0;
        cap_size      = '0;
        cmd_tready    = 1'b0;
        sts_tvalid    = 1'b0;
        sts_tdata     = '0;
        auto_sts      = 1'b0;
`ifdef DAC_RD_LOOP_EN
        loop_en       = 1'b0;
`endif
        exp_q.delete();
        sts_q.delete();
        exp_tag = '0;
        steps(3);
        pl_rstb = 1'b1;
        step();
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_outputs", {cmd_tvalid, busy, done, read_mm2s_err}, 80'(0));
        chk("rst_cmd_tdata", 80'(cmd_tdata), 80'(0));
        chk("rst_current_addr", 80'(current_addr), 80'(0));
        chk("rst_run_cycles", 80'(run_cycles), 80'(0));
        chk("sts_tready", 80'(sts_tready), 80'(1));

        // Three-chunk run with status returned 20 cycles after each command
        cmd_tready    = 1'b1;
        auto_sts      = 1'b1;
        start_address = 32'h1000_0000;
        cap_size      = 32'h0003_0000;
        push_cmd(32'h1000_0000, 23'h10000, 1'b0);
        push_cmd(32'h1001_0000, 23'h10000, 1'b0);
        push_cmd(32'h1002_0000, 23'h10000, 1'b1);
        n0 = n_cmds;
        busy_cnt = 0;
        read_start = 1'b1;
        steps(2);
        chk("t1_busy", 80'(busy), 80'(1));
        wait_idle("t1_idle", 300);
        chk("t1_ncmds", 80'(n_cmds - n0), 80'(3));
        chk("t1_done_err", {done, read_mm2s_err}, 80'(2'b10));
        chk("t1_current_addr", 80'(current_addr), 80'(32'h1002_0000));
        chk("t1_run_cycles", 80'(run_cycles), 80'(busy_cnt));
        chk("t1_exp_empty", 80'(exp_q.size()), 80'(0));
        read_start = 1'b0;
        auto_sts   = 1'b0;
        sts_tvalid = 1'b0;
        steps(2);

        // Outstanding limit, then SLVERR while a command is pending
        do_reset();
        cmd_tready    = 1'b1;
        start_address = 32'h2000_0000;
        cap_size      = 32'h0008_0000;
        for (int i = 0; i < 5; i++) push_cmd(32'h2000_0000 + 32'(i) * 32'h1_0000, 23'h10000, 1'b0);
        n0 = n_cmds;
        read_start = 1'b1;
        steps(30);
        chk("t2_limit_ncmds", 80'(n_cmds - n0), 80'(4));
        chk("t2_limit_valid", 80'(cmd_tvalid), 80'(0));
        cmd_tready = 1'b0;
        send_sts(8'h80);
        steps(5);
        chk("t2_fifth_valid", 80'(cmd_tvalid), 80'(1));
        send_sts(8'h41);
        steps(3);
        chk("t2_err_sticky", 80'(read_mm2s_err), 80'(1));
        chk("t2_pending_valid", 80'(cmd_tvalid), 80'(1));
        cmd_tready = 1'b1;
        steps(12);
        chk("t2_ncmds_after_err", 80'(n_cmds - n0), 80'(5));
        chk("t2_draining", {busy, done}, 80'(2'b10));
        send_sts(8'h82);
        send_sts(8'h83);
        send_sts(8'h84);
        wait_idle("t2_idle", 20);
        chk("t2_done_err", {done, read_mm2s_err}, 80'(2'b11));
        chk("t2_exp_empty", 80'(exp_q.size()), 80'(0));
        read_start = 1'b0;
        steps(2);

        // read_reset while a command is held off by cmd_tready=0
        cmd_tready    = 1'b0;
        auto_sts      = 1'b1;
        start_address = 32'h3000_0000;
        cap_size      = 32'h0003_0000;
        push_cmd(32'h3000_0000, 23'h10000, 1'b0);
        n0 = n_cmds;
        read_start = 1'b1;
        steps(3);
        read_reset = 1'b1;
        steps(2);
        read_reset = 1'b0;
        steps(10);
        chk("t3_held_busy", {busy, cmd_tvalid}, 80'(2'b11));
        cmd_tready = 1'b1;
        steps(2);
        wait_idle("t3_idle", 60);
        chk("t3_ncmds", 80'(n_cmds - n0), 80'(1));
        chk("t3_done_err", {done, read_mm2s_err}, 80'(2'b00));
        chk("t3_current_addr", 80'(current_addr), 80'(32'h3000_0000));
        chk("t3_exp_empty", 80'(exp_q.size()), 80'(0));
        read_start = 1'b0;
        auto_sts   = 1'b0;
        sts_tvalid = 1'b0;
        steps(2);

        // Misaligned size, reset in IDLE, ignored start, zero size, misaligned address
        start_address = 32'h0000_1000;
        cap_size      = 32'h0000_0010;
        read_start    = 1'b1;
        step();
        chk("t4_badsize", {done, read_mm2s_err}, 80'(2'b11));
        steps(3);
        chk("t4_no_cmd", {busy, cmd_tvalid}, 80'(0));
        read_start = 1'b0;
        read_reset = 1'b1;
        step();
        chk("t4_idle_reset", {done, read_mm2s_err}, 80'(0));
        cap_size   = 32'h0;
        read_start = 1'b1;
        steps(2);
        chk("t4_start_ignored", {busy, done}, 80'(0));
        read_start = 1'b0;
        read_reset = 1'b0;
        step();
        read_start = 1'b1;
        step();
        chk("t4_zero_size", {done, read_mm2s_err, busy}, 80'(3'b100));
        read_start = 1'b0;
        step();
        start_address = 32'h0000_1010;
        cap_size      = 32'h0000_0020;
        read_start    = 1'b1;
        step();
        chk("t4_badaddr", {done, read_mm2s_err}, 80'(2'b11));
        steps(3);
        chk("t4_badaddr_no_cmd", {busy, cmd_tvalid}, 80'(0));
        read_start = 1'b0;
        steps(2);

`ifdef DAC_RD_LOOP_EN
        // Looping playback, read_start dropped during the third pass
        do_reset();
        cmd_tready    = 1'b1;
        auto_sts      = 1'b1;
        loop_en       = 1'b1;
        start_address = 32'h4000_0000;
        cap_size      = 32'h0002_0000;
        for (int i = 0; i < 3; i++) begin
            push_cmd(32'h4000_0000, 23'h10000, 1'b0);
            push_cmd(32'h4001_0000, 23'h10000, 1'b1);
        end
        n0 = n_cmds;
        read_start = 1'b1;
        wait_cmds("t5_five", n0 + 5, 200);
        read_start = 1'b0;
        steps(2);
        wait_idle("t5_idle", 200);
        chk("t5_ncmds", 80'(n_cmds - n0), 80'(6));
        chk("t5_done_err", {done, read_mm2s_err}, 80'(2'b10));
        chk("t5_current_addr", 80'(current_addr), 80'(32'h4001_0000));
        chk("t5_exp_empty", 80'(exp_q.size()), 80'(0));
        auto_sts   = 1'b0;
        sts_tvalid = 1'b0;
        steps(2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_dac_rd_cmd_sched
`default_nettype wire
